// File: rtl/sha_stream_ctrl.sv
// sha_stream_ctrl
//
// Byte-stream sequencer for a SHA3-512 core. It receives a length-prefixed
// message (word count N, then 4*N bytes) from a UART receiver and packs the
// bytes big-endian into 32-bit beats for the core. It then captures the
// 512-bit digest and streams it out MSB-first as 64 bytes. It also owns the
// core's reset and re-arms the core after every message or timeout.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   rx_byte_i, rx_valid_i      received byte plus a one-cycle strobe
//   tx_byte_o, tx_valid_o,     digest byte out, using a valid/ready handshake
//   tx_ready_i
//   sha_rst_o                  synchronous active-high reset to the core
//   sha_data_o, sha_valid_o,   data beat into the core; the last beat
//   sha_last_o, sha_ready_i    carries no data
//   sha_hash_i, sha_out_valid_i  digest from the core
//   busy_o                     high whenever the sequencer is not idle
//   overrun_o                  one-cycle pulse: a received byte was dropped
//   timeout_o                  one-cycle pulse: a digest wait was aborted
module sha_stream_ctrl #(
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [7:0]   rx_byte_i,
    input  logic         rx_valid_i,
    output logic [7:0]   tx_byte_o,
    output logic         tx_valid_o,
    input  logic         tx_ready_i,
    output logic         sha_rst_o,
    output logic [31:0]  sha_data_o,
    output logic         sha_valid_o,
    output logic         sha_last_o,
    input  logic         sha_ready_i,
    input  logic [511:0] sha_hash_i,
    input  logic         sha_out_valid_i,
    output logic         busy_o,
    output logic         overrun_o,
    output logic         timeout_o
);

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        RESET_SHA = 3'd0,
        IDLE      = 3'd1,
        COLLECT   = 3'd2,
        PUSH      = 3'd3,
        LAST      = 3'd4,
        WAIT_HASH = 3'd5,
        SEND      = 3'd6
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [RW-1:0]  rst_cnt;
    logic [1:0]     byte_idx;
    logic [7:0]     word_cnt;
    logic [31:0]    word;
    logic [511:0]   hash;
    logic [5:0]     byte_cnt;
    logic [TW-1:0]  tmo_cnt;
    logic           overrun;
    logic           timeout;
    logic [8:0]     bit_hi;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= RESET_SHA;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            RESET_SHA: if (rst_cnt == RST_LAST) state_next = IDLE;
            IDLE: begin
                if (rx_valid_i) begin
                    state_next = (rx_byte_i == 8'd0) ? LAST : COLLECT;
                end
            end
            COLLECT:   if (rx_valid_i && byte_idx == 2'd3) state_next = PUSH;
            PUSH: begin
                if (sha_ready_i) begin
                    state_next = (word_cnt == 8'd1) ? LAST : COLLECT;
                end
            end
            LAST:      if (sha_ready_i) state_next = WAIT_HASH;
            WAIT_HASH: begin
                // A digest arriving in the expiry cycle takes priority.
                if (sha_out_valid_i) begin
                    state_next = SEND;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_next = RESET_SHA;
                end
            end
            SEND:      if (tx_ready_i && byte_cnt == 6'd63) state_next = RESET_SHA;
            default:   state_next = RESET_SHA;
        endcase
    end

    // Counters, word packing, digest capture, status pulses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_cnt  <= '0;
            byte_idx <= '0;
            word_cnt <= '0;
            word     <= '0;
            hash     <= '0;
            byte_cnt <= '0;
            tmo_cnt  <= '0;
            overrun  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            overrun <= rx_valid_i &&
                       (state inside {RESET_SHA, PUSH, LAST, WAIT_HASH, SEND});
            timeout <= (state == WAIT_HASH) && !sha_out_valid_i &&
                       (tmo_cnt == TMO_LAST);

            // Counts RESET_SHA cycles; returns to 0 on exit so the next
            // re-arm starts fresh.
            if (state == RESET_SHA && rst_cnt != RST_LAST) begin
                rst_cnt <= rst_cnt + RW'(1);
            end else begin
                rst_cnt <= '0;
            end

            // Counts cycles spent in WAIT_HASH; expiry is the TIMEOUT-th cycle.
            if (state == WAIT_HASH) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end else begin
                tmo_cnt <= '0;
            end

            case (state)
                IDLE: begin
                    if (rx_valid_i) begin
                        word_cnt <= rx_byte_i;
                        byte_idx <= 2'd0;
                    end
                end
                COLLECT: begin
                    if (rx_valid_i) begin
                        word     <= {word[23:0], rx_byte_i};
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                PUSH: begin
                    if (sha_ready_i) begin
                        word_cnt <= word_cnt - 8'd1;
                        byte_idx <= 2'd0;
                    end
                end
                WAIT_HASH: begin
                    if (sha_out_valid_i) begin
                        hash     <= sha_hash_i;
                        byte_cnt <= 6'd0;
                    end
                end
                SEND: begin
                    if (tx_ready_i) begin
                        byte_cnt <= byte_cnt + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Top bit of the digest byte currently on offer (byte 0 is bits 511:504).
    assign bit_hi = 9'd511 - {byte_cnt, 3'b000};

    // Outputs decoded from state and registers only
    always_comb begin
        sha_rst_o   = 1'b0;
        sha_valid_o = 1'b0;
        sha_last_o  = 1'b0;
        sha_data_o  = '0;
        tx_valid_o  = 1'b0;
        tx_byte_o   = '0;
        busy_o      = (state != IDLE);
        case (state)
            // The final RESET_SHA cycle has the reset released so the core
            // can leave its start state before the first beat.
            RESET_SHA: sha_rst_o = (rst_cnt != RST_LAST);
            PUSH: begin
                sha_valid_o = 1'b1;
                sha_data_o  = word;
            end
            LAST:      sha_last_o = 1'b1;
            SEND: begin
                tx_valid_o = 1'b1;
                tx_byte_o  = hash[bit_hi -: 8];
            end
            default: ;
        endcase
    end

    assign overrun_o = overrun;
    assign timeout_o = timeout;

endmodule

// File: tb/tb_sha_stream_ctrl.sv
// Bench for sha_stream_ctrl. The bench plays UART source, UART sink and the
// SHA core. The core stand-in returns the real SHA3-512 digest for the empty
// message and a deterministic word-dependent pattern otherwise; the reference
// model derives the expected beats and digest bytes from the bytes sent.
`timescale 1ns/1ps
module tb_sha_stream_ctrl;

    localparam int RST_CYCLES = 2;
    localparam int TIMEOUT    = 16;

    localparam logic [511:0] SHA3_EMPTY =
        512'ha69f73cca23a9ac5c8b567dc185a756e97c982164fe25859e0d1dcc1475c80a615b2123af1f5f94c11e3e9402c3ac558f500199d95b6d3e301758586281dcd26;

    logic         clk = 1'b0;
    logic         rst_ni;
    logic [7:0]   rx_byte_i;
    logic         rx_valid_i;
    logic [7:0]   tx_byte_o;
    logic         tx_valid_o;
    logic         tx_ready_i;
    logic         sha_rst_o;
    logic [31:0]  sha_data_o;
    logic         sha_valid_o;
    logic         sha_last_o;
    logic         sha_ready_i;
    logic [511:0] sha_hash_i;
    logic         sha_out_valid_i;
    logic         busy_o;
    logic         overrun_o;
    logic         timeout_o;

    always #5 clk = ~clk;

    sha_stream_ctrl #(
        .RST_CYCLES(RST_CYCLES),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .rx_byte_i      (rx_byte_i),
        .rx_valid_i     (rx_valid_i),
        .tx_byte_o      (tx_byte_o),
        .tx_valid_o     (tx_valid_o),
        .tx_ready_i     (tx_ready_i),
        .sha_rst_o      (sha_rst_o),
        .sha_data_o     (sha_data_o),
        .sha_valid_o    (sha_valid_o),
        .sha_last_o     (sha_last_o),
        .sha_ready_i    (sha_ready_i),
        .sha_hash_i     (sha_hash_i),
        .sha_out_valid_i(sha_out_valid_i),
        .busy_o         (busy_o),
        .overrun_o      (overrun_o),
        .timeout_o      (timeout_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [63:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %0h, expected nothing", name, act);
    endtask

    // Digest the core stand-in produces for a given word sequence.
    function automatic logic [511:0] digest_of(input logic [31:0] w[$]);
        logic [511:0] h;
        logic [31:0]  lane;
        if (w.size() == 0) return SHA3_EMPTY;
        h = SHA3_EMPTY;
        for (int i = 0; i < w.size(); i++) begin
            for (int j = 0; j < 16; j++) begin
                lane = h[j*32 +: 32];
                lane = ((lane << 5) | (lane >> 27)) ^ (w[i] + 32'(j * 7919 + i));
                h[j*32 +: 32] = lane;
            end
        end
        return h;
    endfunction

    // Reference model state
    logic [31:0] exp_words[$];
    logic [7:0]  exp_bytes[$];
    logic [7:0]  msg[$];
    int          data_beats = 0;
    int          last_beats = 0;
    int          tx_count   = 0;
    logic [31:0] first_word = '0;
    logic [7:0]  first_byte = '0;
    logic [7:0]  last_byte  = '0;
    int          cyc = 0;
    int          last_acc_cyc = 0;
    int          tmo_cyc = 0;
    bit          armed = 0;
    bit          tmo_allowed = 0;
    bit          ovr_allowed = 0;

    // Core stand-in and transmit sink
    bit          hash_en    = 1;
    int          hash_delay = 3;
    int          sha_mode   = 0;   // 0: always ready, 1: toggling, 2: random
    int          tx_mode    = 0;   // 0: always ready, 1: random
    logic [31:0] stub_words[$];
    bit          pending  = 0;
    int          wait_cnt = 0;

    initial begin
        sha_ready_i     = 1'b0;
        sha_out_valid_i = 1'b0;
        sha_hash_i      = '0;
        tx_ready_i      = 1'b0;
        forever begin
            @(negedge clk);
            if (sha_rst_o || !rst_ni) begin
                stub_words.delete();
                pending = 0;
            end else begin
                if (sha_valid_o && sha_ready_i) stub_words.push_back(sha_data_o);
                if (sha_last_o && sha_ready_i) begin
                    pending  = 1;
                    wait_cnt = hash_delay;
                end
            end
            @(posedge clk);
            #2;
            sha_out_valid_i = 1'b0;
            if (pending && hash_en) begin
                if (wait_cnt == 0) begin
                    sha_out_valid_i = 1'b1;
                    sha_hash_i      = digest_of(stub_words);
                    pending         = 0;
                    stub_words.delete();
                end else begin
                    wait_cnt--;
                end
            end
            if (sha_mode == 0)      sha_ready_i = 1'b1;
            else if (sha_mode == 1) sha_ready_i = ~sha_ready_i;
            else                    sha_ready_i = 1'($urandom_range(0, 1));
            tx_ready_i = (tx_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Compare process: every cycle outputs are meaningful
    logic        prev_sv = 0, prev_sr = 0, prev_tv = 0, prev_tr = 0;
    logic [31:0] prev_sd = '0;
    logic [7:0]  prev_tb = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst_ni && armed) begin
            if (prev_sv && !prev_sr) begin
                check("data_held_valid", 64'(sha_valid_o), 64'd1);
                check("data_held", 64'(sha_data_o), 64'(prev_sd));
            end
            if (prev_tv && !prev_tr) begin
                check("tx_held_valid", 64'(tx_valid_o), 64'd1);
                check("tx_held", 64'(tx_byte_o), 64'(prev_tb));
            end
            if (sha_valid_o && sha_ready_i) begin
                if (exp_words.size() == 0) flag("beat_unexpected", 64'(sha_data_o));
                else check("beat_data", 64'(sha_data_o), 64'(exp_words.pop_front()));
                if (data_beats == 0) first_word = sha_data_o;
                data_beats++;
            end
            if (sha_last_o) begin
                check("last_no_data", {31'd0, sha_valid_o, sha_data_o}, 64'd0);
                if (sha_ready_i) begin
                    check("last_after_words", 64'(exp_words.size()), 64'd0);
                    last_beats++;
                    last_acc_cyc = cyc;
                end
            end
            if (tx_valid_o && tx_ready_i) begin
                if (exp_bytes.size() == 0) flag("tx_unexpected", 64'(tx_byte_o));
                else check("tx_byte", 64'(tx_byte_o), 64'(exp_bytes.pop_front()));
                if (tx_count == 0) first_byte = tx_byte_o;
                last_byte = tx_byte_o;
                tx_count++;
            end
            if (timeout_o) begin
                tmo_cyc = cyc;
                if (!tmo_allowed) flag("timeout_unexpected", 64'd1);
            end
            if (overrun_o && !ovr_allowed) flag("overrun_unexpected", 64'd1);
            prev_sv = sha_valid_o;
            prev_sr = sha_ready_i;
            prev_sd = sha_data_o;
            prev_tv = tx_valid_o;
            prev_tr = tx_ready_i;
            prev_tb = tx_byte_o;
        end else begin
            prev_sv = 0;
            prev_tv = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        rx_byte_i  = b;
        rx_valid_i = 1'b1;
        tick();
        rx_valid_i = 1'b0;
        rx_byte_i  = 8'h00;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        @(negedge clk);
        while (busy_o && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(busy_o), 64'd0);
    endtask

    task automatic wait_push_done();
        int n = 0;
        @(negedge clk);
        while (sha_valid_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("push_done", 64'(sha_valid_o), 64'd0);
    endtask

    // Builds the expected beats and digest from msg, then sends the message.
    task automatic send_msg(input int n);
        logic [31:0]  words[$];
        logic [511:0] d;
        wait_idle("ready_for_msg", 200);
        for (int i = 0; i < n; i++) begin
            words.push_back({msg[4*i], msg[4*i+1], msg[4*i+2], msg[4*i+3]});
        end
        exp_words.delete();
        exp_bytes.delete();
        foreach (words[i]) exp_words.push_back(words[i]);
        d = digest_of(words);
        for (int k = 0; k < 64; k++) begin
            exp_bytes.push_back(d[511:504]);
            d = d << 8;
        end
        data_beats = 0;
        last_beats = 0;
        tx_count   = 0;
        send_byte(8'(n));
        for (int i = 0; i < 4 * n; i++) begin
            send_byte(msg[i]);
            if (i % 4 == 3) wait_push_done();
        end
    endtask

    task automatic finish_msg(input int n);
        wait_idle("msg_done", 3000);
        check("tx_count", 64'(tx_count), 64'd64);
        check("tx_left", 64'(exp_bytes.size()), 64'd0);
        check("data_beats", 64'(data_beats), 64'(n));
        check("last_beats", 64'(last_beats), 64'd1);
    endtask

    task automatic load_msg(input int nbytes, input logic [7:0] base);
        msg.delete();
        for (int i = 0; i < nbytes; i++) msg.push_back(base + 8'(i * 3));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_ni     = 1'b1;
        rx_valid_i = 1'b0;
        rx_byte_i  = 8'h00;

        // Reset asserted mid-cycle takes effect immediately
        repeat (3) @(posedge clk);
        #3 rst_ni = 1'b0;
        #1;
        check("reset_sha_rst", 64'(sha_rst_o), 64'd1);
        check("reset_busy", 64'(busy_o), 64'd1);
        check("reset_outputs", {19'd0, sha_valid_o, sha_last_o, sha_data_o, tx_valid_o,
                                tx_byte_o, overrun_o, timeout_o}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        armed = 1;

        // Release: RST_CYCLES cycles of core reset, one released cycle, then idle
        @(negedge clk);
        check("rel_c0_rst", 64'(sha_rst_o), 64'd1);
        @(negedge clk);
        check("rel_c1_rst", 64'(sha_rst_o), 64'd1);
        @(negedge clk);
        check("rel_c2_gap", {62'd0, sha_rst_o, busy_o}, 64'd1);
        @(negedge clk);
        check("rel_idle", 64'(busy_o), 64'd0);

        // Empty message
        msg.delete();
        send_msg(0);
        finish_msg(0);
        check("empty_first_byte", 64'(first_byte), 64'ha6);
        check("empty_last_byte", 64'(last_byte), 64'h26);

        // One word "abcd"
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62);
        msg.push_back(8'h63); msg.push_back(8'h64);
        send_msg(1);
        finish_msg(1);
        check("abcd_word", 64'(first_word), 64'h61626364);

        // Three words with toggling core ready and random transmit ready
        sha_mode = 1;
        tx_mode  = 1;
        load_msg(12, 8'h10);
        send_msg(3);
        finish_msg(3);
        sha_mode = 0;

        // Overrun: stray byte during SEND
        load_msg(4, 8'h40);
        send_msg(1);
        n = 0;
        @(negedge clk);
        while (!tx_valid_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_reached", 64'(tx_valid_o), 64'd1);
        ovr_allowed = 1;
        send_byte(8'hAA);
        @(negedge clk);
        check("overrun_pulse", 64'(overrun_o), 64'd1);
        @(negedge clk);
        check("overrun_once", 64'(overrun_o), 64'd0);
        ovr_allowed = 0;
        finish_msg(1);
        tx_mode = 0;

        // Timeout: the core never answers
        hash_en = 0;
        load_msg(4, 8'h70);
        send_msg(1);
        tmo_allowed = 1;
        n = 0;
        @(negedge clk);
        while (!timeout_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_seen", 64'(timeout_o), 64'd1);
        check("timeout_sha_rst", 64'(sha_rst_o), 64'd1);
        @(negedge clk);
        check("timeout_once", 64'(timeout_o), 64'd0);
        check("timeout_delay", 64'(tmo_cyc - last_acc_cyc), 64'd17);
        check("timeout_no_tx", 64'(tx_count), 64'd0);
        tmo_allowed = 0;
        exp_bytes.delete();
        hash_en = 1;
        wait_idle("idle_after_timeout", 50);
        load_msg(4, 8'h90);
        send_msg(1);
        finish_msg(1);

        // Digest arrives in the very cycle the wait would expire
        hash_delay = TIMEOUT - 1;
        load_msg(8, 8'hB0);
        send_msg(2);
        finish_msg(2);
        hash_delay = 3;

        // Reset in the middle of a word
        wait_idle("idle_before_reset", 50);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        #2 rst_ni = 1'b0;
        #1;
        check("midreset_sha_rst", 64'(sha_rst_o), 64'd1);
        check("midreset_busy", 64'(busy_o), 64'd1);
        check("midreset_outputs", {19'd0, sha_valid_o, sha_last_o, sha_data_o, tx_valid_o,
                                   tx_byte_o, overrun_o, timeout_o}, 64'd0);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        exp_words.delete();
        exp_bytes.delete();
        load_msg(4, 8'hC5);
        send_msg(1);
        finish_msg(1);
        check("fresh_word", 64'(first_word), 64'hC5C8CBCE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
